// File: rtl/banderas_pkg.sv
// Shared types for the NZCV status unit: condition codes, flag indices and flag struct.
package banderas_pkg;

  typedef enum logic [3:0] {
    EQ = 4'd0,  NE = 4'd1,  CS = 4'd2,  CC = 4'd3,
    MI = 4'd4,  PL = 4'd5,  VS = 4'd6,  VC = 4'd7,
    HI = 4'd8,  LS = 4'd9,  GE = 4'd10, LT = 4'd11,
    GT = 4'd12, LE = 4'd13, AL = 4'd14, NV = 4'd15
  } cond_e;

  localparam int unsigned IDX_N = 3;
  localparam int unsigned IDX_Z = 2;
  localparam int unsigned IDX_C = 1;
  localparam int unsigned IDX_V = 0;

  // Field order gives n at bit 3 down to v at bit 0, matching the IDX_* positions.
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/registro_banderas_evaluador.sv
// Combinational condition-code evaluator over a held NZCV set; shared with the branch unit.
module evaluador_condicion
  import banderas_pkg::*;
(
  input  flags_t flags,
  input  cond_e  cond,
  output logic   cond_true
);

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      EQ: cond_true = flags.z;
      NE: cond_true = !flags.z;
      CS: cond_true = flags.c;
      CC: cond_true = !flags.c;
      MI: cond_true = flags.n;
      PL: cond_true = !flags.n;
      VS: cond_true = flags.v;
      VC: cond_true = !flags.v;
      HI: cond_true = flags.c && !flags.z;
      LS: cond_true = !flags.c || flags.z;
      GE: cond_true = (flags.n == flags.v);
      LT: cond_true = (flags.n != flags.v);
      GT: cond_true = !flags.z && (flags.n == flags.v);
      LE: cond_true = flags.z || (flags.n != flags.v);
      AL: cond_true = 1'b1;
      NV: cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/registro_banderas.sv
// Registered NZCV flags with per-flag update mask, direct write path,
// sticky overflow, saturating overflow-event counter and condition evaluation.
module registro_banderas
  import banderas_pkg::*;
#(
  parameter int unsigned ANCHO      = 4,
  parameter int unsigned CONT_ANCHO = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  input  logic [ANCHO-1:0]      resultado_i,
  input  logic                  carry_i,
  input  logic                  overflow_i,
  input  logic [3:0]            mask_i,
  input  logic                  flags_we,
  input  logic [3:0]            flags_wdata,
  input  logic                  clr_sticky,
  input  logic [3:0]            cond_i,
  output logic                  N,
  output logic                  Z,
  output logic                  C,
  output logic                  V,
  output logic                  flags_valid,
  output logic                  v_sticky,
  output logic [CONT_ANCHO-1:0] ovf_count,
  output logic                  cond_true
);

  flags_t flags_q;
  flags_t derivadas;
  flags_t siguiente;

  always_comb begin
    derivadas.n = resultado_i[ANCHO-1];
    derivadas.z = (resultado_i == '0);
    derivadas.c = carry_i;
    derivadas.v = overflow_i;
  end

  // Direct write overrides everything; otherwise each flag loads only under its mask bit.
  always_comb begin
    siguiente = flags_q;
    if (flags_we) begin
      siguiente = flags_t'(flags_wdata);
    end else if (valid_i) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (mask_i[i]) siguiente[i] = derivadas[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q     <= '0;
      flags_valid <= 1'b0;
      v_sticky    <= 1'b0;
      ovf_count   <= '0;
    end else begin
      flags_q     <= siguiente;
      flags_valid <= flags_we || valid_i;
      // Clear beats a coincident overflow event, which is then lost.
      if (clr_sticky) begin
        v_sticky  <= 1'b0;
        ovf_count <= '0;
      end else if (valid_i && overflow_i) begin
        v_sticky <= 1'b1;
        if (ovf_count != '1) ovf_count <= ovf_count + CONT_ANCHO'(1);
      end
    end
  end

  assign N = flags_q.n;
  assign Z = flags_q.z;
  assign C = flags_q.c;
  assign V = flags_q.v;

  evaluador_condicion u_evaluador (
    .flags     (flags_q),
    .cond      (cond_e'(cond_i)),
    .cond_true (cond_true)
  );

endmodule

// File: tb/tb_registro_banderas.sv
// Directed-vector bench for registro_banderas (ANCHO=4, CONT_ANCHO=2).
module tb_registro_banderas;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_i;
  logic [3:0] resultado_i;
  logic       carry_i;
  logic       overflow_i;
  logic [3:0] mask_i;
  logic       flags_we;
  logic [3:0] flags_wdata;
  logic       clr_sticky;
  logic [3:0] cond_i;
  logic       N, Z, C, V;
  logic       flags_valid;
  logic       v_sticky;
  logic [1:0] ovf_count;
  logic       cond_true;

  int checks = 0;
  int errors = 0;

  registro_banderas #(.ANCHO(4), .CONT_ANCHO(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_i     (valid_i),
    .resultado_i (resultado_i),
    .carry_i     (carry_i),
    .overflow_i  (overflow_i),
    .mask_i      (mask_i),
    .flags_we    (flags_we),
    .flags_wdata (flags_wdata),
    .clr_sticky  (clr_sticky),
    .cond_i      (cond_i),
    .N           (N),
    .Z           (Z),
    .C           (C),
    .V           (V),
    .flags_valid (flags_valid),
    .v_sticky    (v_sticky),
    .ovf_count   (ovf_count),
    .cond_true   (cond_true)
  );

  always #5 clk = ~clk;

  task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    checks++;
    if (obs !== esp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_i = 1'b0; resultado_i = '0; carry_i = 1'b0; overflow_i = 1'b0;
    mask_i = '0; flags_we = 1'b0; flags_wdata = '0; clr_sticky = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic [3:0] nzcv, input logic fv,
                           input logic st, input logic [1:0] cnt);
    comprobar({tag, ".nzcv"}, {N, Z, C, V}, nzcv);
    comprobar({tag, ".flags_valid"}, flags_valid, fv);
    comprobar({tag, ".v_sticky"}, v_sticky, st);
    comprobar({tag, ".ovf_count"}, ovf_count, cnt);
  endtask

  task automatic check_cond(input string tag, input logic [3:0] c, input logic esp);
    cond_i = c;
    #1;
    comprobar(tag, cond_true, esp);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    cond_i = 4'd14;
    repeat (2) tick();
    check_all("rst_hold", 4'b0000, 1'b0, 1'b0, 2'd0);
    rst_n = 1'b1;
    tick();
    check_all("idle", 4'b0000, 1'b0, 1'b0, 2'd0);
    check_cond("idle.AL", 4'd14, 1'b1);
    check_cond("idle.NV", 4'd15, 1'b0);
    check_cond("idle.EQ", 4'd0, 1'b0);

    // Full update: result 1000, carry, overflow.
    valid_i = 1'b1; resultado_i = 4'b1000; carry_i = 1'b1; overflow_i = 1'b1; mask_i = 4'b1111;
    tick();
    idle();
    check_all("full", 4'b1011, 1'b1, 1'b1, 2'd1);
    check_cond("full.GE", 4'd10, 1'b1);
    check_cond("full.HI", 4'd8, 1'b1);
    check_cond("full.LT", 4'd11, 1'b0);

    // Masked: only Z loads.
    valid_i = 1'b1; resultado_i = 4'b0000; mask_i = 4'b0100;
    tick();
    idle();
    check_all("mask_z", 4'b1111, 1'b1, 1'b1, 2'd1);
    check_cond("mask_z.LS", 4'd9, 1'b1);
    check_cond("mask_z.GT", 4'd12, 1'b0);

    // Direct write wins over simultaneous valid update.
    valid_i = 1'b1; resultado_i = 4'b0000; mask_i = 4'b0100; flags_we = 1'b1; flags_wdata = 4'b0000;
    tick();
    idle();
    check_all("we_wins", 4'b0000, 1'b1, 1'b1, 2'd1);

    tick();
    check_all("no_upd", 4'b0000, 1'b0, 1'b1, 2'd1);

    // Direct write alone, mask ignored.
    flags_we = 1'b1; flags_wdata = 4'b0101; mask_i = 4'b0000;
    tick();
    idle();
    check_all("we_only", 4'b0101, 1'b1, 1'b1, 2'd1);
    check_cond("we_only.LT", 4'd11, 1'b1);
    check_cond("we_only.LE", 4'd13, 1'b1);
    check_cond("we_only.PL", 4'd5, 1'b1);

    // Overflow counting ignores mask: flags hold.
    valid_i = 1'b1; overflow_i = 1'b1; resultado_i = 4'b1000; mask_i = 4'b0000;
    tick();
    idle();
    check_all("ovf_nomask", 4'b0101, 1'b1, 1'b1, 2'd2);

    // Clear alone.
    clr_sticky = 1'b1;
    tick();
    idle();
    check_all("clr", 4'b0101, 1'b0, 1'b0, 2'd0);

    // Five consecutive overflowed results saturate at 3.
    for (int i = 1; i <= 5; i++) begin
      valid_i = 1'b1; overflow_i = 1'b1; resultado_i = 4'b0001; mask_i = 4'b0001;
      tick();
      comprobar($sformatf("sat%0d.ovf_count", i), ovf_count, (i > 3) ? 32'd3 : i);
      comprobar($sformatf("sat%0d.v_sticky", i), v_sticky, 1'b1);
    end
    // Sixth overflow coincides with clear: clear wins.
    clr_sticky = 1'b1;
    tick();
    idle();
    check_all("clr_wins", 4'b0101, 1'b1, 1'b0, 2'd0);

    // Flags to 1111 and counter to 3 via write + overflow events.
    for (int i = 0; i < 3; i++) begin
      flags_we = 1'b1; flags_wdata = 4'b1111; valid_i = 1'b1; overflow_i = 1'b1;
      tick();
    end
    idle();
    check_all("pre_rst", 4'b1111, 1'b1, 1'b1, 2'd3);

    // Asynchronous reset between edges.
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 4'b0000, 1'b0, 1'b0, 2'd0);
    tick();
    rst_n = 1'b1;
    valid_i = 1'b1; resultado_i = 4'b0000; carry_i = 1'b0; overflow_i = 1'b0; mask_i = 4'b1111;
    tick();
    idle();
    check_all("post_rst", 4'b0100, 1'b1, 1'b0, 2'd0);
    check_cond("post_rst.EQ", 4'd0, 1'b1);
    check_cond("post_rst.CC", 4'd3, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/registro_banderas.md
# registro_banderas

Registered NZCV status unit for the parametrised ALU datapath. It captures condition flags from each valid ALU result under a per-flag update mask, and holds them until the next qualified update. It also keeps a sticky overflow bit and a saturating overflow-event counter, and evaluates a 4-bit condition code against the held flags. It sits between the ALU output stage and the control/branch logic, and supports software-style direct flag writes.

## Interface
Parameters:
- ANCHO, 4, result width in bits (≥2)
- CONT_ANCHO, 8, overflow-event counter width (≥1)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous and active-low
- valid_i  input  1  ALU result qualifier
- resultado_i  input  ANCHO  ALU result
- carry_i  input  1  ALU carry-out (already inverted for subtract by the ALU)
- overflow_i  input  1  ALU signed overflow
- mask_i  input  4  per-flag update enable, bit3..0 = N,Z,C,V
- flags_we  input  1  direct flag write strobe
- flags_wdata  input  4  direct write value, bit3..0 = N,Z,C,V
- clr_sticky  input  1  clears v_sticky and ovf_count
- cond_i  input  4  condition code selector
- N, Z, C, V  output  1 each  registered flags
- flags_valid  output  1  one-cycle pulse: flags updated this cycle
- v_sticky  output  1  cumulative overflow since reset/clear
- ovf_count  output  CONT_ANCHO  saturating count of overflowed valid results
- cond_true  output  1  cond_i evaluated on registered flags

## Operation
- Reset (rst_n=0, asynchronous): N=Z=C=V=0, flags_valid=0, v_sticky=0, ovf_count=0.
- Flag derivation on valid_i=1: N = resultado_i[ANCHO-1], Z = (resultado_i == 0), C = carry_i, V = overflow_i. Each flag loads only if its mask_i bit is 1. Unmasked flags hold their value.
- Direct write (flags_we=1): all four flags load flags_wdata. The mask is ignored. This path has priority over valid_i in the same cycle. flags_valid still pulses.
- flags_valid is registered: it is 1 in the cycle after any accepted update (valid_i or flags_we), else 0.
- Sticky/counter: these update on valid_i=1 with overflow_i=1, independent of mask_i[0] and flags_we. v_sticky is set to 1. ovf_count increments, saturating at 2^CONT_ANCHO−1 (no wrap).
- clr_sticky=1 clears v_sticky and ovf_count. It wins over a simultaneous overflow event in the same cycle, so the event is dropped.
- Condition codes (cond_i): 0 EQ Z, 1 NE !Z, 2 CS C, 3 CC !C, 4 MI N, 5 PL !N, 6 VS V, 7 VC !V, 8 HI C&!Z, 9 LS !C|Z, 10 GE N==V, 11 LT N!=V, 12 GT !Z&(N==V), 13 LE Z|(N!=V), 14 AL 1, 15 NV 0.

## Timing
- Latency: inputs sampled at edge k; N/Z/C/V, flags_valid, v_sticky and ovf_count are visible after edge k.
- cond_true is combinational from cond_i and the registered flags. It has no added latency and never reads unregistered ALU inputs.
- Back-to-back valid_i every cycle is supported. There is no stall and no backpressure.
- Reset asserted mid-stream returns all outputs to reset values immediately. The first update after release is taken at the first edge with rst_n=1.

## Structure
- Package banderas_pkg holds:
  - cond_e enum (EQ..NV, 4 bits)
  - localparams IDX_N=3, IDX_Z=2, IDX_C=1, IDX_V=0
  - flags_t packed struct {N,Z,C,V}
- Sub-module evaluador_condicion (combinational: flags_t + cond_e -> cond_true), reusable by the branch unit.

## Test plan
- Reset then idle: all outputs 0, cond_i=14 -> cond_true=1, cond_i=15 -> 0.
- ANCHO=4, valid_i=1, resultado_i=4'b1000, carry_i=1, overflow_i=1, mask_i=4'b1111 -> next cycle N=1, Z=0, C=1, V=1, flags_valid=1, v_sticky=1, ovf_count=1. Then cond_i=10 (GE) -> 1, cond_i=8 (HI) -> 1.
- mask_i=4'b0100 with resultado_i=0 after the case above -> only Z changes: N=0? No, N holds 1, C=1, V=1, Z=1. Same cycle flags_we=1, wdata=4'b0000 -> all flags 0 (write wins).
- CONT_ANCHO=2: 5 consecutive overflowed valid results -> ovf_count saturates at 3. clr_sticky together with a sixth overflow -> ovf_count=0, v_sticky=0.
- Assert rst_n low asynchronously between edges while ovf_count=3 and flags=4'b1111 -> outputs 0 before the next edge. Deassert, apply valid_i -> normal update one edge later.
